// File: rtl/chu_vga_enemy_motion_core_if.sv
// Bus slot interface for the enemy motion core: chip select, read/write
// strobes, register address and the two data paths.
interface chu_vga_enemy_motion_core_if;
  logic        cs;
  logic        write;
  logic        read;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, write, read, addr, wr_data, input rd_data);
  modport slave  (input cs, write, read, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_vga_enemy_motion_core.sv
// Enemy sprite motion core. Once per qualifying frame it moves the sprite
// origin by (dx, dy), bouncing off the visible-area edges and latching
// sticky hit flags. Optional macro ENEMY_WRAP_EN adds a wrap mode
// (ctrl bit1) in which out-of-range positions wrap around instead of bouncing.
module chu_vga_enemy_motion_core #(
  parameter int H_MAX = 640,
  parameter int V_MAX = 480,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [10:0]                   x,
  input  logic [10:0]                   y,
  chu_vga_enemy_motion_core_if.slave    bus,
  output logic [10:0]                   x0,
  output logic [10:0]                   y0,
  output logic                          frame_tick
);

  localparam logic signed [11:0] X_LIM = 12'(H_MAX - SPR_W);
  localparam logic signed [11:0] Y_LIM = 12'(V_MAX - SPR_H);

  typedef enum logic [2:0] {IDLE, WAIT, CALC_X, CALC_Y, COMMIT} state_t;
  state_t state, state_n;

  logic              en;
  logic              wrap;
  logic signed [3:0] dx, dy;
  logic [7:0]        div;
  logic [7:0]        frame_cnt;
  logic              hit_x, hit_y;
  logic signed [11:0] nx_p0, ny_p0;
  logic              blank_q;
  logic              blank;

  logic              wr, wr_ctrl, wr_x, wr_y, wr_dx, wr_dy, wr_div, wr_status;
  logic              commit;
  logic [10:0]       cx, cy;
  logic signed [3:0] ndx, ndy;
  logic              bx, by;
  logic              unused_bits;

  assign unused_bits = &{1'b0, bus.addr[13:3], bus.wr_data[31:11]};

  // Negating -8 in 4 bits would overflow back to -8, so saturate to +7.
  function automatic logic signed [3:0] neg_sat(input logic signed [3:0] d);
    return (d == 4'sb1000) ? 4'sd7 : -d;
  endfunction

  // Resolve one axis: in range passes through; out of range either wraps
  // (velocity kept) or clamps to the edge and reverses velocity.
  function automatic void axis_step(
    input  logic signed [11:0] n,
    input  logic signed [3:0]  d,
    input  logic signed [11:0] lim,
    input  logic               wrap_on,
    output logic [10:0]        pos,
    output logic signed [3:0]  nd,
    output logic               hit
  );
    pos = n[10:0];
    nd  = d;
    hit = 1'b0;
    if (n < 12'sd0) begin
      hit = 1'b1;
      if (wrap_on) pos = 11'(n + lim + 12'sd1);
      else begin
        pos = 11'd0;
        nd  = neg_sat(d);
      end
    end else if (n > lim) begin
      hit = 1'b1;
      if (wrap_on) pos = 11'(n - lim - 12'sd1);
      else begin
        pos = lim[10:0];
        nd  = neg_sat(d);
      end
    end
  endfunction

  assign wr        = bus.cs & bus.write;
  assign wr_ctrl   = wr && (bus.addr[2:0] == 3'd0);
  assign wr_x      = wr && (bus.addr[2:0] == 3'd1);
  assign wr_y      = wr && (bus.addr[2:0] == 3'd2);
  assign wr_dx     = wr && (bus.addr[2:0] == 3'd3);
  assign wr_dy     = wr && (bus.addr[2:0] == 3'd4);
  assign wr_div    = wr && (bus.addr[2:0] == 3'd5);
  assign wr_status = wr && (bus.addr[2:0] == 3'd6);
  assign commit    = (state == COMMIT) && en;
  assign blank     = (x == 11'd0) && (y == 11'(V_MAX));

`ifdef ENEMY_WRAP_EN
  // Wrap-mode bit is only stored when the wrap feature is built in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     wrap <= 1'b0;
    else if (wr_ctrl) wrap <= bus.wr_data[1];
  end
`else
  assign wrap = 1'b0;
`endif

  // Start-of-blank detector: one pulse per entry into (x=0, y=V_MAX),
  // even if the pixel counters dwell there for several clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      blank_q    <= blank;
      frame_tick <= blank & ~blank_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic; clearing enable aborts from any state.
  always_comb begin
    state_n = state;
    if (!en) state_n = IDLE;
    else begin
      case (state)
        IDLE:    state_n = WAIT;
        WAIT:    if (frame_tick && (frame_cnt == div)) state_n = CALC_X;
        CALC_X:  state_n = CALC_Y;
        CALC_Y:  state_n = COMMIT;
        COMMIT:  state_n = WAIT;
        default: state_n = IDLE;
      endcase
    end
  end

  // Edge resolution for the value about to be committed.
  always_comb begin
    axis_step(nx_p0, dx, X_LIM, wrap, cx, ndx, bx);
    axis_step(ny_p0, dy, Y_LIM, wrap, cy, ndy, by);
  end

  // Register file, frame divider and motion datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en        <= 1'b0;
      x0        <= '0;
      y0        <= '0;
      dx        <= '0;
      dy        <= '0;
      div       <= '0;
      frame_cnt <= '0;
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      nx_p0     <= '0;
      ny_p0     <= '0;
    end else begin
      if (wr_ctrl) en  <= bus.wr_data[0];
      if (wr_div)  div <= bus.wr_data[7:0];

      // Preload the divider on enable so the first frame after enabling moves.
      if (state == IDLE && en)
        frame_cnt <= div;
      else if (state == WAIT && en && frame_tick)
        frame_cnt <= (frame_cnt == div) ? 8'd0 : frame_cnt + 8'd1;

      // stage p0: candidate positions
      if (state == CALC_X) nx_p0 <= $signed({1'b0, x0}) + {{8{dx[3]}}, dx};
      if (state == CALC_Y) ny_p0 <= $signed({1'b0, y0}) + {{8{dy[3]}}, dy};

      // commit stage: bus writes take priority over computed results
      if (wr_x)        x0 <= bus.wr_data[10:0];
      else if (commit) x0 <= cx;
      if (wr_y)        y0 <= bus.wr_data[10:0];
      else if (commit) y0 <= cy;
      if (wr_dx)       dx <= bus.wr_data[3:0];
      else if (commit) dx <= ndx;
      if (wr_dy)       dy <= bus.wr_data[3:0];
      else if (commit) dy <= ndy;

      if (commit && bx)   hit_x <= 1'b1;
      else if (wr_status) hit_x <= 1'b0;
      if (commit && by)   hit_y <= 1'b1;
      else if (wr_status) hit_y <= 1'b0;
    end
  end

  // Combinational register readback for the selected slot.
  always_comb begin
    bus.rd_data = 32'd0;
    if (bus.cs && bus.read) begin
      case (bus.addr[2:0])
        3'd0:    bus.rd_data = {30'd0, wrap, en};
        3'd1:    bus.rd_data = {21'd0, x0};
        3'd2:    bus.rd_data = {21'd0, y0};
        3'd3:    bus.rd_data = {{28{dx[3]}}, dx};
        3'd4:    bus.rd_data = {{28{dy[3]}}, dy};
        3'd5:    bus.rd_data = {24'd0, div};
        3'd6:    bus.rd_data = {30'd0, hit_y, hit_x};
        default: bus.rd_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_chu_vga_enemy_motion_core.sv
// Directed bench for the enemy motion core: register access, per-frame
// motion timing, bounce/wrap edges, divider, abort and mid-move reset.
module tb_chu_vga_enemy_motion_core;
  localparam logic [2:0] A_CTRL = 3'd0, A_X = 3'd1, A_Y = 3'd2, A_DX = 3'd3,
                         A_DY = 3'd4, A_DIV = 3'd5, A_ST = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y, x0, y0;
  logic        frame_tick;
  int          n_checks = 0;
  int          n_fail = 0;
  int          pulses;
  logic [31:0] exp_x, exp_dx, exp_ctrl;

  chu_vga_enemy_motion_core_if bus();

  chu_vga_enemy_motion_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .bus        (bus),
    .x0         (x0),
    .y0         (y0),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled on the next rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = {11'd0, a}; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = {11'd0, a};
    #1 d = bus.rd_data;
    bus.cs = 1'b0; bus.read = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic tick();
    x = 11'd0; y = 11'd480;
    @(negedge clk);
    x = 11'd1; y = 11'd0;
    check("frame_tick_hi", {31'd0, frame_tick}, 32'd1);
  endtask

  // Origin must still be old 3 cycles after the tick cycle, new one later.
  task automatic move(input string tag, input logic [10:0] ox, input logic [10:0] oy,
                      input logic [10:0] nxx, input logic [10:0] nyy);
    tick();
    @(negedge clk);
    check({tag, "_tick_lo"}, {31'd0, frame_tick}, 32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_old"}, {10'd0, x0, y0}, {10'd0, ox, oy});
    @(negedge clk);
    check({tag, "_new"}, {10'd0, x0, y0}, {10'd0, nxx, nyy});
  endtask

  initial begin
    reset_n = 1'b0;
    bus.cs = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.addr = '0; bus.wr_data = '0;
    x = 11'd1; y = 11'd0;
    repeat (2) @(negedge clk);
    check("rst_pos", {10'd0, x0, y0}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    rd_check("rst_ctrl", A_CTRL, 32'd0);
    rd_check("rst_dx", A_DX, 32'd0);
    rd_check("rst_status", A_ST, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Counters dwelling at the blank point give a single pulse.
    x = 11'd0; y = 11'd480; pulses = 0;
    repeat (4) begin @(negedge clk); pulses += int'(frame_tick); end
    x = 11'd1; y = 11'd0;
    check("tick_single", pulses, 32'd1);
    @(negedge clk);

    // Basic motion, one step per frame.
    bus_write(A_X, 32'd100);
    check("wr_x_next", {21'd0, x0}, 32'd100);
    bus_write(A_DX, 32'd4);
    bus_write(A_DIV, 32'd0);
    bus_write(A_CTRL, 32'd1);
    rd_check("ctrl_en", A_CTRL, 32'd1);
    move("m1", 11'd100, 11'd0, 11'd104, 11'd0);
    move("m2", 11'd104, 11'd0, 11'd108, 11'd0);
    move("m3", 11'd108, 11'd0, 11'd112, 11'd0);

    // Right-edge bounce.
    bus_write(A_X, 32'd606);
    move("bounce_r", 11'd606, 11'd0, 11'd608, 11'd0);
    rd_check("bounce_r_dx", A_DX, 32'hFFFF_FFFC);
    rd_check("bounce_r_st", A_ST, 32'd1);
    move("after_bounce", 11'd608, 11'd0, 11'd604, 11'd0);
    bus_write(A_ST, 32'd0);
    rd_check("st_clear", A_ST, 32'd0);

    // Exact edges accepted without bounce.
    bus_write(A_DX, 32'd4);
    move("edge_r", 11'd604, 11'd0, 11'd608, 11'd0);
    rd_check("edge_r_st", A_ST, 32'd0);
    rd_check("edge_r_dx", A_DX, 32'd4);
    bus_write(A_X, 32'd4);
    bus_write(A_DX, 32'hC);
    move("edge_l", 11'd4, 11'd0, 11'd0, 11'd0);
    rd_check("edge_l_st", A_ST, 32'd0);

    // -8 negates to +7.
    bus_write(A_X, 32'd3);
    bus_write(A_DX, 32'h8);
    move("sat", 11'd3, 11'd0, 11'd0, 11'd0);
    rd_check("sat_dx", A_DX, 32'd7);
    rd_check("sat_st", A_ST, 32'd1);
    bus_write(A_ST, 32'd0);

    // Wrap request: honoured only when the feature is built in.
`ifdef ENEMY_WRAP_EN
    exp_x = 32'd607; exp_dx = 32'hFFFF_FFFC; exp_ctrl = 32'd3;
`else
    exp_x = 32'd0;   exp_dx = 32'd4;         exp_ctrl = 32'd1;
`endif
    bus_write(A_X, 32'd2);
    bus_write(A_DX, 32'hC);
    bus_write(A_CTRL, 32'd3);
    move("wrap", 11'd2, 11'd0, exp_x[10:0], 11'd0);
    rd_check("wrap_dx", A_DX, exp_dx);
    rd_check("wrap_ctrl", A_CTRL, exp_ctrl);
    rd_check("wrap_st", A_ST, 32'd1);
    bus_write(A_ST, 32'd0);
    bus_write(A_CTRL, 32'd1);

    // Bottom edge: exact limit, then bounce.
    bus_write(A_X, 32'd300);
    bus_write(A_DX, 32'd0);
    bus_write(A_Y, 32'd444);
    bus_write(A_DY, 32'd4);
    move("edge_b", 11'd300, 11'd444, 11'd300, 11'd448);
    rd_check("edge_b_st", A_ST, 32'd0);
    move("bounce_b", 11'd300, 11'd448, 11'd300, 11'd448);
    rd_check("bounce_b_dy", A_DY, 32'hFFFF_FFFC);
    rd_check("bounce_b_st", A_ST, 32'd2);
    bus_write(A_ST, 32'd0);

    // Frame divider of 2: moves on ticks 1 and 4.
    bus_write(A_CTRL, 32'd0);
    bus_write(A_DY, 32'd1);
    bus_write(A_Y, 32'd10);
    bus_write(A_DIV, 32'd2);
    bus_write(A_CTRL, 32'd1);
    move("div_t1", 11'd300, 11'd10, 11'd300, 11'd11);
    tick(); repeat (5) @(negedge clk);
    check("div_t2", {21'd0, y0}, 32'd11);
    tick(); repeat (5) @(negedge clk);
    check("div_t3", {21'd0, y0}, 32'd11);
    move("div_t4", 11'd300, 11'd11, 11'd300, 11'd12);

    // Disable right after a qualifying tick aborts the move.
    bus_write(A_CTRL, 32'd0);
    bus_write(A_DIV, 32'd0);
    bus_write(A_X, 32'd77);
    bus_write(A_CTRL, 32'd1);
    tick();
    bus_write(A_CTRL, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_pos", {10'd0, x0, y0}, {10'd0, 11'd77, 11'd12});
    check("abort_state", 32'(dut.state), 32'd0);

    // Bus write during the commit cycle beats the computed value.
    bus_write(A_CTRL, 32'd1);
    bus_write(A_X, 32'd50);
    bus_write(A_DX, 32'd1);
    tick();
    repeat (3) @(negedge clk);
    bus_write(A_X, 32'd200);
    check("commit_wr_x", {21'd0, x0}, 32'd200);
    check("commit_y", {21'd0, y0}, 32'd13);

    // Flag set beats a simultaneous status clear.
    bus_write(A_X, 32'd608);
    tick();
    repeat (3) @(negedge clk);
    bus_write(A_ST, 32'd0);
    rd_check("set_wins_st", A_ST, 32'd1);
    check("set_wins_x", {21'd0, x0}, 32'd608);
    rd_check("set_wins_dx", A_DX, 32'hFFFF_FFFF);
    bus_write(A_ST, 32'd0);
    rd_check("set_wins_clr", A_ST, 32'd0);

    // Reset asserted in CALC_Y clears at once; nothing commits afterwards.
    bus_write(A_X, 32'd300);
    tick();
    repeat (2) @(negedge clk);
    check("pre_rst_state", 32'(dut.state), 32'd3);
    reset_n = 1'b0;
    #1;
    check("rst_async_pos", {10'd0, x0, y0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_pos", {10'd0, x0, y0}, 32'd0);
    rd_check("post_rst_ctrl", A_CTRL, 32'd0);
    tick();
    repeat (5) @(negedge clk);
    check("post_rst_tick_pos", {10'd0, x0, y0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/chu_vga_enemy_motion_core.md
CHU_VGA_ENEMY_MOTION_CORE -- requirements
Module: chu_vga_enemy_motion_core

Interface
REQ-001 SHALL have parameter H_MAX, 640, visible width in pixels.
REQ-002 SHALL have parameter V_MAX, 480, visible height in lines.
REQ-003 SHALL have parameter SPR_W, 32, sprite width; SPR_H, 32, sprite height.
REQ-004 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports x, y  in  11 each  frame counter pixel coordinates.
REQ-007 SHALL have ports cs, write, read  in  1 each  video slot select and strobes.
REQ-008 SHALL have port addr  in  14  slot register address; only addr[2:0] decoded.
REQ-009 SHALL have port wr_data  in  32  write data; rd_data  out  32  read data.
REQ-010 SHALL have ports x0, y0  out  11 each  sprite origin fed to the enemy sprite core.
REQ-011 SHALL have port frame_tick  out  1  one-cycle start-of-blank pulse.

Function
REQ-012 SHALL decode registers: 0 ctrl (bit0 enable, bit1 wrap), 1 x_pos, 2 y_pos, 3 dx (signed 4-bit), 4 dy (signed 4-bit), 5 div (8-bit), 6 status.
REQ-013 SHALL load x0/y0 on the cycle after a write to x_pos/y_pos (wr_data[10:0]), in any state.
REQ-014 SHALL drive rd_data combinationally: ctrl, x0, y0, dx, dy sign-extended, div, status {30'b0, hit_y, hit_x}; unused addresses read 0.
REQ-015 SHALL pulse frame_tick for exactly one cycle when x==0 and y==V_MAX.
REQ-016 SHALL implement FSM IDLE, WAIT, CALC_X, CALC_Y, COMMIT.
REQ-017 IDLE->WAIT when enable=1; any state->IDLE the cycle after enable cleared, aborting without commit.
REQ-018 WAIT: on frame_tick, if frame_cnt==div then clear frame_cnt and go CALC_X, else increment frame_cnt and stay.
REQ-019 CALC_X computes 12-bit signed nx = x0 + sext(dx); CALC_Y likewise ny with dy; COMMIT updates x0/y0, then returns to WAIT.
REQ-020 x0/y0 SHALL change exactly 3 cycles after the qualifying frame_tick; never outside vertical blank except by bus write.
REQ-021 Bounce: nx<0 -> x0=0, dx negated, hit_x set; nx>H_MAX-SPR_W -> x0=H_MAX-SPR_W, dx negated, hit_x set; same for y with V_MAX-SPR_H, hit_y.
REQ-022 nx exactly 0 or exactly H_MAX-SPR_W SHALL be accepted without bounce or flag.
REQ-023 dx or dy of -8 SHALL negate to +7 (saturate).
REQ-024 hit_x/hit_y SHALL be sticky, cleared by any write to status.
REQ-025 Bus write to x_pos/y_pos/dx/dy in the COMMIT cycle SHALL win over the computed value.
REQ-026 Flag set and status-clear write in same cycle: set wins.

Reset
REQ-027 On reset_n=0 all outputs and registers SHALL clear asynchronously: x0=0, y0=0, frame_tick=0, ctrl=0, dx=dy=0, div=0, frame_cnt=0, flags=0, state IDLE.
REQ-028 Reset mid-move SHALL discard the computation; no commit follows release.

Configuration
REQ-029 Macro ENEMY_WRAP_EN defined: ctrl bit1=1 makes out-of-range nx/ny wrap (nx<0 -> nx+H_MAX-SPR_W+1; nx>H_MAX-SPR_W -> nx-(H_MAX-SPR_W+1)), dx/dy unchanged, hit flag still set.
REQ-030 Macro undefined: ctrl bit1 not stored, reads 0, bounce always applies.

Verification
REQ-031 enable=1, x_pos=100, dx=+4, div=0, 3 frames -> x0=104,108,112, each 3 cycles after frame_tick.
REQ-032 x_pos=606, dx=+4 -> x0=608, dx reads 0xFFFFFFFC, hit_x=1; next frame x0=604.
REQ-033 div=2, dy=+1, y_pos=10 -> y0 increments once per 3 frame_ticks: 11 at tick 1, 12 at tick 4.
REQ-034 Clear enable the cycle after qualifying frame_tick -> x0/y0 unchanged, state IDLE.
REQ-035 With ENEMY_WRAP_EN, wrap=1, x_pos=2, dx=-4 -> x0=607, dx=-4, hit_x=1; without macro -> x0=0, dx=+4.
REQ-036 Assert reset_n low during CALC_Y -> x0=y0=0 immediately; after release no update until re-enabled and next tick.
